// File: rtl/serial_accum4.sv
// serial_accum4: accumulator whose additions run bit-serially through one
// full-adder slice, LSB first, one bit per clock. Operands arrive on a
// valid/ready handshake; acc/ovf update once per addition and done pulses
// for the cycle after the update.
module serial_accum4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             done
);

  // Counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;    // operand, shifted right each ADD cycle
  logic [WIDTH-1:0] res;    // starts as acc, sum bits enter at the MSB
  logic             carry;
  logic [CW-1:0]    cnt;

  logic a, b, sum, cout, accept, last;

  // A clear takes priority over accepting a new operand.
  assign din_ready = (state == IDLE) && !clr;
  assign accept    = din_valid && din_ready;

  // The single full-adder slice.
  assign a    = opa[0];
  assign b    = res[0];
  assign sum  = a ^ b ^ carry;
  assign cout = (a & b) | (a & carry) | (b & carry);
  assign last = (cnt == CW'(WIDTH - 1));

  // FSM plus datapath: load on accept, one bit per ADD cycle, commit on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
          end else if (accept) begin
            opa   <= din;
            res   <= acc;
            carry <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          if (clr) begin
            // Abort: partial result is discarded, no done pulse.
            acc   <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end else begin
            opa   <= {1'b0, opa[WIDTH-1:1]};
            res   <= {sum, res[WIDTH-1:1]};
            carry <= cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
              acc   <= {sum, res[WIDTH-1:1]};
              ovf   <= cout;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // done is already high this cycle; clr still wipes the result.
          if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
